// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/gnt word fetches and buffers responses in an in-order prefetch queue.
// Optional macro FETCH_PREDECODE_EN stores a predecoded immediate type per queue entry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemGnt,
  input  logic        i_imemRvalid,
  input  logic [31:0] i_imemRdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  output logic [2:0]  o_immType
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      r_fetchPc;
  logic [31:0]      r_respPc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;
  logic [31:0]      r_instQ [DEPTH];
  logic [31:0]      r_pcQ   [DEPTH];

  logic             w_valid;
  logic             w_req;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_redirPc;
  logic [CNT_W-1:0] w_inFlight;

  // Credit: in-flight requests plus buffered words never exceed the queue size.
  assign w_inFlight = r_outstanding + r_count;
  assign w_valid    = (r_count != '0);
  assign w_req      = !i_rst && !i_redirect && (w_inFlight < DEPTH_C);
  assign w_grant    = w_req && i_imemGnt;
  assign w_push     = i_imemRvalid && !i_redirect && (r_drop == '0);
  assign w_pop      = w_valid && i_ready && !i_redirect;
  assign w_redirPc  = {i_redirectPc[31:2], 2'b00};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (i_redirect) begin
      // Everything still in flight after this cycle's response is stale.
      r_fetchPc     <= w_redirPc;
      r_respPc      <= w_redirPc;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CNT_W'(i_imemRvalid);
      r_drop        <= r_outstanding - CNT_W'(i_imemRvalid);
    end else begin
      if (w_grant) r_fetchPc <= r_fetchPc + 32'd4;
      if (w_push) begin
        r_respPc <= r_respPc + 32'd4;
        r_tail   <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(i_imemRvalid);
      if (i_imemRvalid && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_instQ[r_tail] <= i_imemRdata;
      r_pcQ[r_tail]   <= r_respPc;
    end
  end

  assign o_imemReq  = w_req;
  assign o_imemAddr = r_fetchPc;
  assign o_valid    = w_valid;
  assign o_inst     = w_valid ? r_instQ[r_head] : 32'h0;
  assign o_pc       = w_valid ? r_pcQ[r_head] : RESET_PC;

`ifdef FETCH_PREDECODE_EN
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  logic [2:0] r_immQ [DEPTH];

  function automatic logic [2:0] predecode(input logic [6:0] opcode);
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: predecode = IMM_I;
      7'b0100011:                         predecode = IMM_S;
      7'b1100011:                         predecode = IMM_B;
      7'b0110111, 7'b0010111:             predecode = IMM_U;
      7'b1101111:                         predecode = IMM_J;
      default:                            predecode = 3'b000;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_push) r_immQ[r_tail] <= predecode(i_imemRdata[6:0]);
  end

  assign o_immType = w_valid ? r_immQ[r_head] : 3'b000;
`else
  assign o_immType = 3'b000;
`endif

`ifndef SYNTHESIS
  // A response may only land in a full queue if the head leaves the same cycle.
  assert property (@(posedge i_clk) disable iff (i_rst)
    w_push |-> ((r_count != DEPTH_C) || w_pop));
  assert property (@(posedge i_clk) disable iff (i_rst)
    i_imemRvalid |-> (r_outstanding != '0));
`endif

endmodule
